// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter among four byte requesters
module uart_tx_arbiter #(
    parameter int TIMEOUT_CYCLES = 16000,
    parameter int CNT_W          = 15
) (
    input  logic        tck,
    input  logic        reset,
    input  logic [3:0]  req,
    input  logic [31:0] req_data,
    output logic [3:0]  ack,
    output logic        uart_tx_enable,
    output logic [7:0]  uart_tx_data,
    input  logic        uart_tx_done,
    output logic [1:0]  grant_id,
    output logic        busy,
    output logic        timeout_err,
    input  logic        err_clear
);
    typedef enum logic [1:0] {IDLE, START, WAIT} state_t;
    state_t           state_q, state_d;
    logic [3:0]       ack_q, ack_d;
    logic [7:0]       data_q, data_d;
    logic [1:0]       grant_q, grant_d, last_q, last_d;
    logic [CNT_W-1:0] wd_q, wd_d;
    logic             err_q, err_d;
    logic [1:0]       pick, cand;
    logic             found;
    logic             expired;
    assign expired = (wd_q == CNT_W'(TIMEOUT_CYCLES - 1));
    // search last_grant+1 .. last_grant+4 and keep the first requester found
    always_comb begin
        pick  = 2'd0;
        cand  = 2'd0;
        found = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            cand = last_q + 2'(i);
            if (!found && req[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
    end
    // next-state: grant in IDLE, one-cycle enable in START, wait for done or watchdog in WAIT
    always_comb begin
        state_d = state_q;
        ack_d   = 4'b0000;
        data_d  = data_q;
        grant_d = grant_q;
        last_d  = last_q;
        wd_d    = wd_q;
        err_d   = err_clear ? 1'b0 : err_q;
        case (state_q)
            IDLE: if (found) begin
                data_d  = req_data[{pick, 3'b000} +: 8];
                grant_d = pick;
                state_d = START;
            end
            START: begin
                wd_d    = '0;
                state_d = WAIT;
            end
            WAIT: begin
                wd_d = wd_q + 1'b1;
                if (uart_tx_done) begin
                    ack_d   = 4'b0001 << grant_q;
                    last_d  = grant_q;
                    state_d = IDLE;
                end else if (expired) begin
                    err_d   = 1'b1;
                    last_d  = grant_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    // state register; last_q resets to 3 so requester 0 is searched first
    always_ff @(posedge tck or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            ack_q   <= 4'b0000;
            data_q  <= 8'h00;
            grant_q <= 2'd0;
            last_q  <= 2'd3;
            wd_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            data_q  <= data_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            wd_q    <= wd_d;
            err_q   <= err_d;
        end
    end
    assign ack            = ack_q;
    assign uart_tx_enable = (state_q == START);
    assign uart_tx_data   = data_q;
    assign grant_id       = grant_q;
    assign busy           = (state_q != IDLE);
    assign timeout_err    = err_q;
endmodule
